// File: rtl/outperiph_pkg.sv
// Shared definitions for the output-peripheral bank and its front-end arbiter.
// Register map: one 32-bit register every 16 bytes, HEX0 at 0x00 through LEDG at 0x90.
package outperiph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [7:0] ADDR_HEX0 = 8'h00;
    localparam logic [7:0] ADDR_HEX1 = 8'h10;
    localparam logic [7:0] ADDR_HEX2 = 8'h20;
    localparam logic [7:0] ADDR_HEX3 = 8'h30;
    localparam logic [7:0] ADDR_HEX4 = 8'h40;
    localparam logic [7:0] ADDR_HEX5 = 8'h50;
    localparam logic [7:0] ADDR_HEX6 = 8'h60;
    localparam logic [7:0] ADDR_HEX7 = 8'h70;
    localparam logic [7:0] ADDR_LEDR = 8'h80;
    localparam logic [7:0] ADDR_LEDG = 8'h90;

    function automatic logic is_legal_addr(input logic [7:0] addr);
        return (addr[3:0] == 4'h0) && (addr[7:4] <= ADDR_LEDG[7:4]);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping modulo NREQ.
// Returns the winner as both a one-hot vector and a binary index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int c;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(last) + k) % NREQ;
            if (!any && req[c]) begin
                any       = 1'b1;
                onehot[c] = 1'b1;
                idx       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/outperiph_arbiter.sv
// Round-robin front end sharing the single-port HEX/LED register bank between NREQ requesters.
// Each transaction runs IDLE/RESP (arbitrate) -> ACCESS (grant, touch bank) -> RESP (respond).
module outperiph_arbiter
    import outperiph_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*8-1:0]  addr,
    input  logic [NREQ*32-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [31:0]        rdata,
    output logic               err,
    output logic [7:0]         p_addr,
    output logic [31:0]        p_wdata,
    output logic               p_wren,
    input  logic [31:0]        p_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, win_q;
    logic            we_q, legal_q, err_q;
    logic [7:0]      addr_q;
    logic [31:0]     wdata_q, rdata_q;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any, take;
    logic            sel_we;
    logic [7:0]      sel_addr;
    logic [31:0]     sel_wdata;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*8 +: 8];
                sel_wdata = wdata[i*32 +: 32];
            end
        end
    end

    // RESP arbitrates like IDLE, so back-to-back transactions cost two cycles each.
    assign take = pick_any && (state_q != ACCESS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = take ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = take ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            win_q   <= '0;
            we_q    <= 1'b0;
            legal_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_q  <= pick_idx;
                win_q   <= pick_idx;
                we_q    <= sel_we;
                legal_q <= is_legal_addr(sel_addr);
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                rdata_q <= legal_q ? p_rdata : '0;
                err_q   <= ~legal_q;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        rvalid  = '0;
        p_addr  = '0;
        p_wdata = '0;
        p_wren  = 1'b0;
        if (state_q == ACCESS) begin
            gnt[win_q] = 1'b1;
            p_addr     = addr_q;
            p_wdata    = wdata_q;
            p_wren     = we_q & legal_q;
        end
        if (state_q == RESP) begin
            rvalid[win_q] = 1'b1;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_outperiph_arbiter.sv
// Scoreboard bench for outperiph_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model with its own shadow register bank.
module tb_outperiph_arbiter;

    localparam int NREQ = 3;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req, we, gnt, rvalid;
    logic [NREQ*8-1:0]  addr;
    logic [NREQ*32-1:0] wdata;
    logic [31:0]        rdata, p_wdata, p_rdata;
    logic               err, p_wren;
    logic [7:0]         p_addr;

    outperiph_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .err     (err),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_wren  (p_wren),
        .p_rdata (p_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Peripheral stand-in; illegal addresses return junk so the arbiter's zeroing is visible.
    logic [31:0] bank [0:15];
    assign p_rdata = (p_addr % 16 == 0 && p_addr / 16 <= 9) ? bank[p_addr[7:4]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (p_wren) bank[p_addr[7:4]] <= p_wdata;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [7:0] a);
        return (a % 16 == 0) && (a / 16 <= 9);
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: phase 0 = waiting, 1 = bank access, 2 = responding.
    logic [31:0] shadow [0:15];
    int          m_phase, m_last, m_win;
    bit          m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;

    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            exp_q.delete();
            check("rst_gnt", 32'(gnt), 0);
            check("rst_rvalid", 32'(rvalid), 0);
            check("rst_rdata", rdata, 0);
            check("rst_err", 32'(err), 0);
            check("rst_paddr", 32'(p_addr), 0);
            check("rst_pwdata", p_wdata, 0);
            check("rst_pwren", 32'(p_wren), 0);
        end else begin
            if (m_phase == 1) begin
                exp_t e;
                e.idx = m_win;
                e.err = !legal(m_addr);
                e.rd  = legal(m_addr) ? shadow[m_addr / 16] : 32'h0;
                if (legal(m_addr) && m_we) shadow[m_addr / 16] = m_wdata;
                exp_q.push_back(e);
                m_phase = 2;
            end else if (req != 0) begin
                m_win   = rr_next(req, m_last);
                m_last  = m_win;
                m_we    = we[m_win];
                m_addr  = addr[m_win*8 +: 8];
                m_wdata = wdata[m_win*32 +: 32];
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
            check("gnt", 32'(gnt), (m_phase == 1) ? (32'd1 << m_win) : 32'd0);
            check("rvalid", 32'(rvalid), (m_phase == 2) ? (32'd1 << m_win) : 32'd0);
            check("p_addr", 32'(p_addr), (m_phase == 1) ? 32'(m_addr) : 32'd0);
            check("p_wdata", p_wdata, (m_phase == 1) ? m_wdata : 32'd0);
            check("p_wren", 32'(p_wren), 32'((m_phase == 1) && m_we && legal(m_addr)));
        end
    end

    // Response monitor: pops one expectation per observed rvalid.
    always begin
        @(posedge clk);
        #2;
        if (rst && rvalid != 0) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'(rvalid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_idx", 32'(rvalid), 32'd1 << e.idx);
                check("resp_rdata", rdata, e.rd);
                check("resp_err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic set_txn(input int i, input bit w, input logic [7:0] a, input logic [31:0] d);
        req[i]            = 1'b1;
        we[i]             = w;
        addr[i*8 +: 8]    = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic txn(input int i, input bit w, input logic [7:0] a, input logic [31:0] d);
        bit got;
        @(negedge clk);
        set_txn(i, w, a, d);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (gnt[i]) got = 1;
        end
        check("grant_wait", 32'(got), 1);
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          seq [$];
        bit          got, saw1;
        logic [7:0]  a;

        for (int i = 0; i < 16; i++) begin
            bank[i]   = 32'h0;
            shadow[i] = 32'h0;
        end
        req = '0; we = '0; addr = '0; wdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_gnt", 32'(gnt), 0);
        check("reset_pwren", 32'(p_wren), 0);
        @(negedge clk) rst = 1'b1;

        // Single write, read-back, illegal accesses, LEDG round trip.
        txn(0, 1'b1, 8'h30, 32'h1234_5678);
        txn(0, 1'b0, 8'h30, 32'h0);
        txn(0, 1'b1, 8'h34, 32'hAAAA_5555);
        txn(0, 1'b1, 8'hA0, 32'h5555_AAAA);
        txn(2, 1'b0, 8'h34, 32'h0);
        txn(1, 1'b1, 8'h90, 32'h0000_00FF);
        txn(1, 1'b0, 8'h90, 32'h0);
        repeat (2) @(negedge clk);

        // Contention: requesters 0 and 1 held continuously.
        set_txn(0, 1'b0, 8'h10, 32'h0);
        set_txn(1, 1'b0, 8'h20, 32'h0);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (gnt != 0) seq.push_back(gnt == 3'b001 ? 0 : (gnt == 3'b010 ? 1 : 99));
        end
        req = '0;
        check("contention_count", seq.size(), 6);
        foreach (seq[k]) check("contention_order", seq[k], k % 2);
        repeat (3) @(negedge clk);

        // Withdrawal: requester 1 pulses within the cycle requester 0 is picked.
        saw1 = 0;
        got  = 0;
        set_txn(0, 1'b0, 8'h40, 32'h0);
        set_txn(1, 1'b1, 8'h50, 32'h1111_2222);
        #2 req[1] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (gnt[0]) begin
                got    = 1;
                req[0] = 1'b0;
            end
            if (gnt[1]) saw1 = 1;
        end
        check("withdraw_gnt0", 32'(got), 1);
        check("withdraw_no_gnt1", 32'(saw1), 0);

        // Reset during ACCESS of a write: no bank update, no response, pointer restored.
        got = 0;
        @(negedge clk);
        set_txn(0, 1'b1, 8'h50, 32'hCAFE_F00D);
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            if (gnt[0]) got = 1;
        end
        check("abort_grant_wait", 32'(got), 1);
        rst = 1'b0;
        req = '0;
        #1;
        check("abort_gnt", 32'(gnt), 0);
        check("abort_pwren", 32'(p_wren), 0);
        check("abort_paddr", 32'(p_addr), 0);
        check("abort_rvalid", 32'(rvalid), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_write", bank[5], shadow[5]);
        set_txn(0, 1'b0, 8'h50, 32'h0);
        set_txn(1, 1'b0, 8'h60, 32'h0);
        got = 0;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            if (gnt != 0) begin
                got = 1;
                check("post_reset_first", 32'(gnt), 32'b001);
            end
        end
        check("post_reset_grant_wait", 32'(got), 1);
        req = '0;
        repeat (3) @(negedge clk);

        // Random traffic with re-requests and occasional withdrawals.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                a = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0))
                                                : 8'($urandom_range(9, 0) * 16);
                if (req[i] && gnt[i]) begin
                    if ($urandom_range(1, 0) == 1) set_txn(i, 1'($urandom_range(1, 0)), a, $urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(9, 0) < 4) set_txn(i, 1'($urandom_range(1, 0)), a, $urandom);
                end else if ($urandom_range(99, 0) < 3) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (6) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
